// File: rtl/monobit_block_test.sv
// NIST SP800-22 frequency (monobit) tester: scores 2**LOG2_N-bit blocks of a serial stream.
// Define MONOBIT_STATS_EN to add saturating pass/fail block counters.
module monobit_block_test #(
    parameter int LOG2_N = 7,
    parameter int THRESH = 29,
    localparam int SUM_W = LOG2_N + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             done,
    output logic             pass,
    output logic [SUM_W-1:0] sum,
    output logic             busy
`ifdef MONOBIT_STATS_EN
    ,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t                    state_q, state_d;
    logic signed [SUM_W-1:0]   acc_q, acc_d;
    logic        [LOG2_N-1:0]  cnt_q, cnt_d;
    logic        [SUM_W-1:0]   sum_q, sum_d;
    logic                      pass_q, pass_d;

    logic                      accept;
    logic                      last_bit;
    logic                      finish;
    logic signed [SUM_W-1:0]   acc_step;
    logic signed [SUM_W-1:0]   acc_final;
    logic signed [SUM_W:0]     acc_ext;
    logic        [SUM_W:0]     abs_final;
    logic                      result_pass;

    always_comb begin
        // An abort in flight must refuse the bit offered in the same cycle.
        bit_ready   = (state_q == ACCUM) && en && !clr;
        accept      = bit_ready && bit_valid;
        last_bit    = (cnt_q == {LOG2_N{1'b1}});
        acc_step    = bit_in ? SUM_W'(1) : {SUM_W{1'b1}};
        acc_final   = acc_q + acc_step;
        // One extra bit so that |-N| is representable.
        acc_ext     = {acc_final[SUM_W-1], acc_final};
        abs_final   = acc_ext[SUM_W] ? unsigned'(-acc_ext) : unsigned'(acc_ext);
        result_pass = (abs_final <= (SUM_W+1)'(THRESH));
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        pass_d  = pass_q;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = ACCUM;
            end
            ACCUM: begin
                if (!en || clr) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = en ? ACCUM : IDLE;
                end else if (accept) begin
                    if (last_bit) begin
                        sum_d   = acc_final;
                        pass_d  = result_pass;
                        acc_d   = '0;
                        cnt_d   = '0;
                        finish  = 1'b1;
                        state_d = REPORT;
                    end else begin
                        acc_d = acc_final;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = en ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            pass_q  <= pass_d;
        end
    end

    assign done = (state_q == REPORT);
    assign busy = (state_q == ACCUM) && (cnt_q != '0);
    assign sum  = sum_q;
    assign pass = pass_q;

`ifdef MONOBIT_STATS_EN
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;

    // Counters move on the same edge as sum/pass so they are current while done is high.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (finish && result_pass && pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
        if (finish && !result_pass && fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_monobit_block_test.sv
// Self-checking bench for monobit_block_test: directed and random blocks against a counting model.
module tb_monobit_block_test;

    localparam int N  = 128;
    localparam int TH = 29;

    typedef bit bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, clr = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
    logic       bit_ready, done, pass, busy;
    logic [8:0] sum;
    logic       en2 = 1'b0, bit_in2 = 1'b0, bit_valid2 = 1'b0;
    logic       ready2, done2, pass2, busy2;
    logic [4:0] sum2;
`ifdef MONOBIT_STATS_EN
    logic [15:0] pass_cnt, fail_cnt, pass_cnt2, fail_cnt2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    monobit_block_test #(.LOG2_N(7), .THRESH(29)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .done(done), .pass(pass), .sum(sum), .busy(busy)
`ifdef MONOBIT_STATS_EN
        , .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
    );

    monobit_block_test #(.LOG2_N(3), .THRESH(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .clr(1'b0), .bit_in(bit_in2), .bit_valid(bit_valid2),
        .bit_ready(ready2), .done(done2), .pass(pass2), .sum(sum2), .busy(busy2)
`ifdef MONOBIT_STATS_EN
        , .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build(output bq_t q, input int ones, input int zeros, input bit alt);
        q = {};
        if (alt) for (int i = 0; i < ones + zeros; i++) q.push_back(bit'(i % 2 == 0));
        else begin
            for (int i = 0; i < ones; i++) q.push_back(1'b1);
            for (int i = 0; i < zeros; i++) q.push_back(1'b0);
        end
    endtask

    function automatic int ref_sum(input bq_t q);
        int s = 0;
        foreach (q[i]) s += q[i] ? 1 : -1;
        return s;
    endfunction

    function automatic int ref_pass(input int s, input int th);
        return ((s < 0 ? -s : s) <= th) ? 1 : 0;
    endfunction

    // Offer bits from q with random valid gaps; check the strobe and result one cycle after the last accept.
    task automatic run_block(input bq_t q, input int gap, input string tag);
        int idx = 0, cyc = 0, early = 0, s;
        while (idx < q.size() && cyc < 4000) begin
            @(negedge clk);
            bit_valid = ($urandom_range(99) >= gap);
            bit_in = bit_valid ? q[idx] : 1'($urandom_range(1));
            #1;
            if (done) early++;
            if (bit_valid && bit_ready) idx++;
            cyc++;
        end
        check({tag, "_accepts"}, idx, q.size());
        check({tag, "_early_done"}, early, 0);
        @(negedge clk);
        bit_valid = 1'($urandom_range(1));
        #1;
        s = ref_sum(q);
        check({tag, "_done"}, done, 1);
        check({tag, "_ready_in_report"}, bit_ready, 0);
        check({tag, "_sum"}, int'($signed(sum)), s);
        check({tag, "_pass"}, pass, ref_pass(s, TH));
        bit_valid = 1'b0;
    endtask

    task automatic feed(input int n, input int gap);
        int idx = 0, cyc = 0;
        while (idx < n && cyc < 4000) begin
            @(negedge clk);
            bit_valid = ($urandom_range(99) >= gap);
            bit_in = 1'($urandom_range(1));
            #1;
            if (bit_valid && bit_ready) idx++;
            cyc++;
        end
        check("feed_accepts", idx, n);
    endtask

    task automatic run8(input bq_t q, input string tag);
        int idx = 0, cyc = 0, s;
        while (idx < q.size() && cyc < 200) begin
            @(negedge clk);
            bit_valid2 = 1'b1;
            bit_in2 = q[idx];
            #1;
            if (ready2) idx++;
            cyc++;
        end
        @(negedge clk);
        bit_valid2 = 1'b0;
        #1;
        s = ref_sum(q);
        check({tag, "_done"}, done2, 1);
        check({tag, "_sum"}, int'($signed(sum2)), s);
        check({tag, "_pass"}, pass2, ref_pass(s, 0));
    endtask

    initial begin
        bq_t q;
        int  ndone, held_sum, held_pass, s;

        // Reset state
        #12;
        check("rst_ready", bit_ready, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_sum", sum, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 128 ones, continuous valid; ready returns right after the report cycle
        en = 1'b1;
        build(q, 128, 0, 1'b0);
        run_block(q, 0, "ones");
        @(negedge clk);
        #1;
        check("ones_ready_after", bit_ready, 1);
        check("ones_done_1cyc", done, 0);

        // Threshold edges around |S| = 29
        build(q, 64, 64, 1'b1);
        run_block(q, 0, "alt");
        build(q, 78, 50, 1'b0);
        run_block(q, 0, "p28");
        build(q, 79, 49, 1'b0);
        run_block(q, 0, "p30");

        // Sparse valid
        build(q, 50, 78, 1'b0);
        run_block(q, 50, "gap");

        // Random blocks, random gaps
        for (int b = 0; b < 4; b++) begin
            q = {};
            for (int i = 0; i < N; i++) q.push_back(1'($urandom_range(1)));
            run_block(q, $urandom_range(60), "rnd");
        end

        // en dropped mid-block: no result, bit refused, results held
        held_sum = int'(sum);
        held_pass = int'(pass);
        feed(60, 0);
        @(negedge clk);
        #1;
        check("abort_busy", busy, 1);
        en = 1'b0;
        bit_valid = 1'b1;
        #1;
        check("abort_ready_comb", bit_ready, 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_ready_next", bit_ready, 0);
        check("abort_busy_clear", busy, 0);
        check("abort_no_done", ndone, 0);
        check("abort_sum_held", int'(sum), held_sum);
        check("abort_pass_held", int'(pass), held_pass);
        bit_valid = 1'b0;

        // clr mid-block restarts the count from zero
        en = 1'b1;
        feed(60, 20);
        @(negedge clk);
        clr = 1'b1;
        bit_valid = 1'b1;
        #1;
        check("clr_ready_comb", bit_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        bit_valid = 1'b0;
        #1;
        check("clr_busy_clear", busy, 0);
        build(q, 0, 128, 1'b0);
        run_block(q, 0, "clr_zeros");

        // Async reset lands between edges
        build(q, 78, 50, 1'b0);
        run_block(q, 0, "pre_rst");
        feed(30, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", bit_ready, 0);
        check("arst_done", done, 0);
        check("arst_pass", pass, 0);
        check("arst_sum", sum, 0);
        check("arst_busy", busy, 0);
        en = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // N=8, THRESH=0 instance
        en2 = 1'b1;
        build(q, 4, 4, 1'b0);
        run8(q, "n8_bal");
        build(q, 5, 3, 1'b0);
        run8(q, "n8_p2");
        en2 = 1'b0;

`ifdef MONOBIT_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int b = 0; b < 3; b++) begin
            build(q, 64, 64, 1'b1);
            run_block(q, 30, "st_pass");
        end
        for (int b = 0; b < 2; b++) begin
            build(q, 100, 28, 1'b0);
            run_block(q, 30, "st_fail");
        end
        check("stats_pass_cnt", pass_cnt, 3);
        check("stats_fail_cnt", fail_cnt, 2);
        @(negedge clk);
        force dut.fail_cnt_q = 16'hFFFE;
        #1;
        release dut.fail_cnt_q;
        for (int b = 0; b < 2; b++) begin
            build(q, 0, 128, 1'b0);
            run_block(q, 0, "st_sat");
        end
        check("stats_fail_sat", fail_cnt, 16'hFFFF);
        check("stats_pass_keep", pass_cnt, 3);
        en = 1'b0;
`endif

        s = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
